multicycle_alu: RTL and testbench

//  Parametrised, registered ALU for the RISC-V datapath. Extends the 64-bit opcode set with

---
 rtl/multicycle_alu_if.sv | 27 ++
 rtl/multicycle_alu.sv | 168 ++++++++++++++++
 tb/tb_multicycle_alu.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_alu_if.sv
// Request/response bundle for multicycle_alu.
//   master: drives start/operation/operand1/operand2, observes ready/done/result/flags
//   slave : the ALU side
interface multicycle_alu_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [3:0]       operation;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zeroFlag;
  logic             divByZero;
  logic             illegalOp;

  modport master (
    output start, operation, operand1, operand2,
    input  ready, done, result, zeroFlag, divByZero, illegalOp
  );

  modport slave (
    input  start, operation, operand1, operand2,
    output ready, done, result, zeroFlag, divByZero, illegalOp
  );
endinterface

// File: rtl/multicycle_alu.sv
// Registered multi-cycle ALU. Single-cycle ops complete one cycle after start;
// mul (shift-add) and divu/remu (restoring) iterate one bit per cycle.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of multicycle_alu_if (start/operation/operands in,
//           ready/done/result/zeroFlag/divByZero/illegalOp out)
module multicycle_alu #(
  parameter int unsigned WIDTH      = 64,
  parameter bit          MUL_DIV_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  multicycle_alu_if.slave bus
);
  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned CNTW = SHW + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB, OP_MUL, OP_DIVU, OP_SLL, OP_SRL, OP_SRA,
    OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_REMU
  } op_e;

  state_e           state_q;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q;    // mul: shifting multiplicand; div: dividend -> quotient
  logic [WIDTH-1:0] b_q;    // mul: shifting multiplier;   div: divisor
  logic [WIDTH-1:0] acc_q;  // mul: partial product;       div: partial remainder
  logic             rem_sel_q;
  logic             ready_q, done_q, zero_q, dbz_q, ill_q;
  logic [WIDTH-1:0] result_q;

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] single_res;
  logic             single_ill, single_dbz, go_mul, go_div;
  logic [WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_d, div_quo_d, div_fin_d;

  always_comb begin
    sh         = bus.operand2[SHW-1:0];
    single_res = '0;
    single_ill = 1'b0;
    single_dbz = 1'b0;
    go_mul     = 1'b0;
    go_div     = 1'b0;
    case (bus.operation)
      OP_ADD:  single_res = bus.operand1 + bus.operand2;
      OP_SUB:  single_res = bus.operand1 - bus.operand2;
      OP_MUL: begin
        if (MUL_DIV_EN) go_mul = 1'b1;
        else            single_ill = 1'b1;
      end
      OP_DIVU, OP_REMU: begin
        if (!MUL_DIV_EN) begin
          single_ill = 1'b1;
        end else if (bus.operand2 == '0) begin
          single_dbz = 1'b1;
          single_res = (bus.operation == OP_DIVU) ? '1 : bus.operand1;
        end else begin
          go_div = 1'b1;
        end
      end
      OP_SLL:  single_res = bus.operand1 << sh;
      OP_SRL:  single_res = bus.operand1 >> sh;
      OP_SRA:  single_res = $unsigned($signed(bus.operand1) >>> sh);
      OP_AND:  single_res = bus.operand1 & bus.operand2;
      OP_OR:   single_res = bus.operand1 | bus.operand2;
      OP_XOR:  single_res = bus.operand1 ^ bus.operand2;
      OP_SLT:  single_res = WIDTH'($signed(bus.operand1) < $signed(bus.operand2));
      OP_SLTU: single_res = WIDTH'(bus.operand1 < bus.operand2);
      default: single_ill = 1'b1;
    endcase

    mul_acc_d = acc_q + (b_q[0] ? a_q : '0);

    // Restoring step: shift next dividend bit into remainder, subtract if it fits.
    // The subtraction only matters when trial >= divisor, where it fits in WIDTH bits.
    div_trial = {acc_q, a_q[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, b_q});
    div_rem_d = div_ge ? (div_trial[WIDTH-1:0] - b_q) : div_trial[WIDTH-1:0];
    div_quo_d = {a_q[WIDTH-2:0], div_ge};
    div_fin_d = rem_sel_q ? div_rem_d : div_quo_d;
  end

  // The final iteration writes result/flags and raises done on the edge that
  // enters FIN, so done is visible during the FIN cycle (start + WIDTH + 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_sel_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      dbz_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (go_mul || go_div) begin
              a_q       <= bus.operand1;
              b_q       <= bus.operand2;
              acc_q     <= '0;
              rem_sel_q <= (bus.operation == OP_REMU);
              cnt_q     <= CNTW'(WIDTH);
              ready_q   <= 1'b0;
              state_q   <= go_mul ? S_MUL : S_DIV;
            end else begin
              result_q <= single_res;
              zero_q   <= (single_res == '0);
              dbz_q    <= single_dbz;
              ill_q    <= single_ill;
              done_q   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q <= mul_acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNTW'(1)) begin
            result_q <= mul_acc_d;
            zero_q   <= (mul_acc_d == '0);
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_FIN;
          end
        end
        S_DIV: begin
          acc_q <= div_rem_d;
          a_q   <= div_quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNTW'(1)) begin
            result_q <= div_fin_d;
            zero_q   <= (div_fin_d == '0);
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_FIN;
          end
        end
        S_FIN: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.zeroFlag  = zero_q;
  assign bus.divByZero = dbz_q;
  assign bus.illegalOp = ill_q;
endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(64)) bus ();
  multicycle_alu_if #(.WIDTH(64)) bus0 ();

  multicycle_alu #(.WIDTH(64), .MUL_DIV_EN(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  multicycle_alu #(.WIDTH(64), .MUL_DIV_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  int tests = 0;
  int fails = 0;
  logic [63:0] prev_res = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: plain arithmetic from the opcode table.
  function automatic void model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                input bit en, output logic [63:0] r, output logic dbz,
                                output logic ill, output int lat);
    int sh;
    sh  = int'(b[5:0]);
    r   = '0; dbz = 1'b0; ill = 1'b0; lat = 1;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: if (en) begin r = a * b; lat = 65; end else ill = 1'b1;
      4'h3: if (!en) ill = 1'b1; else if (b == 0) begin r = '1; dbz = 1'b1; end
            else begin r = a / b; lat = 65; end
      4'h4: r = a << sh;
      4'h5: r = a >> sh;
      4'h6: r = $signed(a) >>> sh;
      4'h7: r = a & b;
      4'h8: r = a | b;
      4'h9: r = a ^ b;
      4'hA: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'hB: r = (a < b) ? 64'd1 : 64'd0;
      4'hC: if (!en) ill = 1'b1; else if (b == 0) begin r = a; dbz = 1'b1; end
            else begin r = a % b; lat = 65; end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input bit noise, input string tag);
    logic [63:0] er;
    logic edbz, eill;
    int elat, cyc;
    bit seen;
    model(op, a, b, 1'b1, er, edbz, eill, elat);
    cyc = 0;
    @(negedge clk);
    while (!bus.ready && cyc < 10) begin @(negedge clk); cyc++; end
    chk({tag, "_ready"}, 64'(bus.ready), 64'd1);
    bus.start = 1'b1; bus.operation = op; bus.operand1 = a; bus.operand2 = b;
    @(posedge clk);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk); cyc++;
      if (bus.done) begin
        seen = 1'b1;
        bus.start = 1'b0;
      end else begin
        chk({tag, "_busy"}, 64'(bus.ready), 64'd0);
        chk({tag, "_hold"}, bus.result, prev_res);
        bus.start     = noise;
        bus.operation = 4'h0;
        bus.operand1  = {$urandom(), $urandom()};
        bus.operand2  = {$urandom(), $urandom()};
      end
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(elat));
    chk({tag, "_res"}, bus.result, er);
    chk({tag, "_zero"}, 64'(bus.zeroFlag), 64'(er == 0));
    chk({tag, "_dbz"}, 64'(bus.divByZero), 64'(edbz));
    chk({tag, "_ill"}, 64'(bus.illegalOp), 64'(eill));
    prev_res = er;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [63:0] a, b;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.operation = '0; bus.operand1 = '0; bus.operand2 = '0;
    bus0.start = 1'b0; bus0.operation = '0; bus0.operand1 = '0; bus0.operand2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_flags", {61'd0, bus.zeroFlag, bus.divByZero, bus.illegalOp}, 64'd0);
    rst_n = 1'b1;

    run_op(4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "add_wrap");

    // back-to-back subtracts: second start lands in the done cycle of the first
    @(negedge clk);
    bus.start = 1'b1; bus.operation = 4'h1; bus.operand1 = 64'd5; bus.operand2 = 64'd5;
    @(posedge clk); @(negedge clk);
    chk("b2b_done1", 64'(bus.done), 64'd1);
    chk("b2b_res1", bus.result, 64'd0);
    chk("b2b_zero1", 64'(bus.zeroFlag), 64'd1);
    chk("b2b_ready1", 64'(bus.ready), 64'd1);
    bus.operand1 = 64'd3;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_done2", 64'(bus.done), 64'd1);
    chk("b2b_res2", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("b2b_zero2", 64'(bus.zeroFlag), 64'd0);
    prev_res = 64'hFFFF_FFFF_FFFF_FFFE;

    run_op(4'h2, 64'h1_0000_0001, 64'h1_0000_0001, 1'b1, "mul_noise");
    chk("mul_const", bus.result, 64'h0000_0002_0000_0001);
    run_op(4'h3, 64'd100, 64'd7, 1'b0, "divu");
    chk("divu_const", bus.result, 64'd14);
    run_op(4'hC, 64'd100, 64'd7, 1'b0, "remu");
    chk("remu_const", bus.result, 64'd2);
    run_op(4'h3, 64'd9, 64'd0, 1'b0, "divu_by0");
    run_op(4'hC, 64'd9, 64'd0, 1'b0, "remu_by0");
    run_op(4'h6, 64'h8000_0000_0000_0000, 64'h41, 1'b0, "sra");
    chk("sra_const", bus.result, 64'hC000_0000_0000_0000);
    run_op(4'hA, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "slt");
    run_op(4'hB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "sltu");

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = 64'($urandom_range(1, 200));
        default: b = {$urandom(), $urandom()};
      endcase
      run_op(op, a, b, i[0], "rand");
    end
    run_op(4'hC, 64'd9, 64'd0, 1'b0, "pre_rst");

    // reset mid-division: everything clears and the aborted op never completes
    @(negedge clk);
    bus.start = 1'b1; bus.operation = 4'h3; bus.operand1 = 64'd1000; bus.operand2 = 64'd3;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(bus.ready), 64'd1);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_result", bus.result, 64'd0);
    chk("abort_flags", {61'd0, bus.zeroFlag, bus.divByZero, bus.illegalOp}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("abort_nodone", 64'(bus.done), 64'd0);
    end
    prev_res = '0;
    run_op(4'hF, 64'd12, 64'd34, 1'b0, "illegal");

    // MUL_DIV_EN=0 instance
    @(negedge clk);
    bus0.start = 1'b1; bus0.operation = 4'h2; bus0.operand1 = 64'd6; bus0.operand2 = 64'd7;
    @(posedge clk); @(negedge clk);
    chk("nomd_mul_done", 64'(bus0.done), 64'd1);
    chk("nomd_mul_ill", 64'(bus0.illegalOp), 64'd1);
    chk("nomd_mul_res", bus0.result, 64'd0);
    chk("nomd_mul_zero", 64'(bus0.zeroFlag), 64'd1);
    bus0.operation = 4'h0; bus0.operand1 = 64'd2; bus0.operand2 = 64'd3;
    @(posedge clk); @(negedge clk);
    chk("nomd_add_res", bus0.result, 64'd5);
    chk("nomd_add_ill", 64'(bus0.illegalOp), 64'd0);
    bus0.operation = 4'hC; bus0.operand2 = 64'd0;
    @(posedge clk); @(negedge clk);
    bus0.start = 1'b0;
    chk("nomd_rem_ill", 64'(bus0.illegalOp), 64'd1);
    chk("nomd_rem_dbz", 64'(bus0.divByZero), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
